// File: rtl/pc_fetch_unit.sv
// Fetch-PC owner: issues one outstanding imem request at a time, applies
// ID/EX redirects, squashes stale responses and drives the IF/ID outputs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir_id_valid,
  input  logic [31:0] redir_id_target,
  input  logic        redir_ex_valid,
  input  logic [31:0] redir_ex_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic        flush_ifid,
  output logic        flush_idex
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, pend_pc, buf_pc, buf_instr;
  logic        buf_valid;
  logic        redir, gnt_ok, rsp, rsp_live;
  logic [31:0] redir_target;

  // EX holds the older instruction, so its redirect wins
  assign redir        = redir_ex_valid | redir_id_valid;
  assign redir_target = (redir_ex_valid ? redir_ex_target : redir_id_target) & ~32'h3;

  assign imem_req   = (state == FETCH) & !buf_valid & !stall & !rst;
  assign imem_addr  = fetch_pc;
  assign flush_ifid = redir & !rst;
  assign flush_idex = redir_ex_valid & !rst;

  assign gnt_ok   = imem_req & imem_gnt;
  assign rsp      = imem_rvalid & (state != FETCH);
  assign rsp_live = rsp & (state == WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (gnt_ok) state_nxt = redir ? DROP : WAIT;
      WAIT:    if (rsp) state_nxt = FETCH;
               else if (redir) state_nxt = DROP;
      DROP:    if (rsp) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      pend_pc   <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
      if_valid  <= 1'b0;
      pc_if     <= '0;
      instr_if  <= '0;
    end else if (redir) begin
      // redirect beats stall; any in-flight response becomes stale
      fetch_pc  <= redir_target;
      if_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      if (gnt_ok) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (!stall) begin
        if (rsp_live) begin
          if_valid <= 1'b1;
          pc_if    <= pend_pc;
          instr_if <= imem_rdata;
        end else if (buf_valid) begin
          if_valid  <= 1'b1;
          pc_if     <= buf_pc;
          instr_if  <= buf_instr;
          buf_valid <= 1'b0;
        end else begin
          if_valid <= 1'b0;
        end
      end else if (rsp_live) begin
        // outputs are frozen: park the response until stall drops
        buf_valid <= 1'b1;
        buf_pc    <= pend_pc;
        buf_instr <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus a randomized run against a queue-based fetch model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_id_valid, redir_ex_valid, stall;
  logic [31:0] redir_id_target, redir_ex_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, flush_ifid, flush_idex;
  logic [31:0] pc_if, instr_if;
  logic        w_req, w_if_valid, w_fi, w_fx;
  logic [31:0] w_addr, w_pc_if, w_instr_if;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .redir_id_valid(redir_id_valid), .redir_id_target(redir_id_target),
    .redir_ex_valid(redir_ex_valid), .redir_ex_target(redir_ex_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .pc_if(pc_if), .instr_if(instr_if),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .redir_id_valid(redir_id_valid), .redir_id_target(redir_id_target),
    .redir_ex_valid(redir_ex_valid), .redir_ex_target(redir_ex_target),
    .stall(stall), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(w_if_valid), .pc_if(w_pc_if), .instr_if(w_instr_if),
    .flush_ifid(w_fi), .flush_idex(w_fx)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; redir_id_valid = 1'b0; redir_ex_valid = 1'b0; stall = 1'b0;
    redir_id_target = '0; redir_ex_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
  endtask

  task automatic reset_dut();
    set_idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle(); rst = 1'b1; redir_ex_valid = 1'b1; redir_ex_target = 32'h40; imem_gnt = 1'b1;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b%0b exp=00", flush_ifid, flush_idex); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
    checks++; if (pc_if !== 32'h0 || instr_if !== 32'h0) begin failures++; $display("FAIL reset_outs got=%h/%h exp=0/0", pc_if, instr_if); end
    checks++; if (w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_pc_param got=%h exp=fffffffc", w_addr); end
    set_idle();
  endtask

  task automatic test_boot();
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      imem_gnt = 1'b1; #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin failures++; $display("FAIL boot_req k=%0d got=%0b/%h exp=1/%h", k, imem_req, imem_addr, 32'(4*k)); end
      if (k > 0) begin
        checks++; if (if_valid !== 1'b1 || pc_if !== 32'(4*(k-1)) || instr_if !== instr_of(32'(4*(k-1)))) begin failures++; $display("FAIL boot_out k=%0d got=%0b/%h/%h exp=1/%h/%h", k, if_valid, pc_if, instr_if, 32'(4*(k-1)), instr_of(32'(4*(k-1)))); end
      end
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'(4*k)); #1;
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL boot_wait k=%0d got req=%0b ifv=%0b exp=0/0", k, imem_req, if_valid); end
      tick();
      imem_rvalid = 1'b0;
    end
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h8 || instr_if !== instr_of(32'h8)) begin failures++; $display("FAIL boot_last got=%0b/%h/%h exp=1/8/%h", if_valid, pc_if, instr_if, instr_of(32'h8)); end
  endtask

  task automatic test_stall_rsp();
    reset_dut();
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h0); tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0 || pc_if !== 32'h0 || instr_if !== instr_of(32'h0)) begin failures++; $display("FAIL stall_hold got=%0b/%h/%h exp=0/0/%h", if_valid, pc_if, instr_if, instr_of(32'h0)); end
    for (int i = 0; i < 2; i++) begin
      imem_gnt = 1'b1; #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_noreq i=%0d got=%0b exp=0", i, imem_req); end
      tick();
    end
    stall = 1'b0; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL buf_noreq got=%0b exp=0", imem_req); end
    imem_gnt = 1'b0; tick();
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h4 || instr_if !== 32'h0050_0093) begin failures++; $display("FAIL stall_release got=%0b/%h/%h exp=1/4/00500093", if_valid, pc_if, instr_if); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL stall_next got=%0b/%h exp=1/8", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; redir_ex_valid = 1'b1; redir_ex_target = 32'h100; #1;
    checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin failures++; $display("FAIL redir_flush got=%0b%0b exp=11", flush_ifid, flush_idex); end
    tick();
    redir_ex_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL redir_drop got req=%0b ifv=%0b exp=0/0", imem_req, if_valid); end
    tick();
    imem_rvalid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_refetch got=%0b/%0b/%h exp=0/1/100", if_valid, imem_req, imem_addr); end
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h100); tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h100 || instr_if !== instr_of(32'h100)) begin failures++; $display("FAIL redir_target_out got=%0b/%h/%h exp=1/100/%h", if_valid, pc_if, instr_if, instr_of(32'h100)); end
  endtask

  task automatic test_simul_redir();
    redir_id_valid = 1'b1; redir_id_target = 32'h200;
    redir_ex_valid = 1'b1; redir_ex_target = 32'h300; #1;
    checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin failures++; $display("FAIL simul_flush got=%0b%0b exp=11", flush_ifid, flush_idex); end
    tick();
    redir_id_valid = 1'b0; redir_ex_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL simul_prio got=%0b/%h exp=1/300", imem_req, imem_addr); end
    redir_ex_valid = 1'b1; redir_ex_target = 32'h302; tick();
    redir_ex_valid = 1'b0; #1;
    checks++; if (imem_addr !== 32'h300) begin failures++; $display("FAIL align got=%h exp=300", imem_addr); end
    redir_id_valid = 1'b1; redir_id_target = 32'h404; #1;
    checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin failures++; $display("FAIL id_flush got=%0b%0b exp=10", flush_ifid, flush_idex); end
    tick();
    redir_id_valid = 1'b0; #1;
    checks++; if (imem_addr !== 32'h404) begin failures++; $display("FAIL id_target got=%h exp=404", imem_addr); end
  endtask

  task automatic test_gnt_redirect();
    imem_gnt = 1'b1; redir_id_valid = 1'b1; redir_id_target = 32'h500; #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL gntredir_req got=%0b exp=1", imem_req); end
    tick();
    imem_gnt = 1'b0; redir_id_valid = 1'b0; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL gntredir_drop got=%0b exp=0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD; tick();
    imem_rvalid = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h500 || if_valid !== 1'b0) begin failures++; $display("FAIL gntredir_after got=%0b/%h/%0b exp=1/500/0", imem_req, imem_addr, if_valid); end
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'h500); tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h500) begin failures++; $display("FAIL gntredir_out got=%0b/%h exp=1/500", if_valid, pc_if); end
  endtask

  task automatic test_wrap();
    reset_dut(); #1;
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%0b/%h exp=1/fffffffc", w_req, w_addr); end
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr_of(32'hFFFF_FFFC); tick();
    imem_rvalid = 1'b0; #1;
    checks++; if (w_addr !== 32'h0 || w_if_valid !== 1'b1 || w_pc_if !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_second got=%h/%0b/%h exp=0/1/fffffffc", w_addr, w_if_valid, w_pc_if); end
  endtask

  task automatic test_rst_mid();
    imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rstmid_req got=%0b/%h exp=1/0", imem_req, imem_addr); end
    tick();
    imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ignore got=%0b exp=0", if_valid); end
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          live;
    int          rdy;
  } ent_t;

  ent_t q[$];

  // Model: queue of in-flight requests tagged live/stale, a one-slot skid
  // and an output slot, updated once per cycle from the applied inputs.
  task automatic test_random();
    logic [31:0] m_pc, m_opc, m_oin, m_spc, m_sin, tgt;
    bit m_ov, m_sv, m_req, redirect, acc, live_rsp, loaded;
    ent_t e;
    int cyc;
    int bad;
    reset_dut();
    q.delete();
    m_pc = 32'h0; m_ov = 0; m_sv = 0; m_opc = '0; m_oin = '0; m_spc = '0; m_sin = '0;
    cyc = 0; bad = 0;
    for (int n = 0; n < 3000; n++) begin
      checks++;
      if (if_valid !== m_ov || (m_ov && (pc_if !== m_opc || instr_if !== m_oin))) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rnd_out cyc=%0d got=%0b/%h/%h exp=%0b/%h/%h", cyc, if_valid, pc_if, instr_if, m_ov, m_opc, m_oin);
      end
      stall           = ($urandom_range(0, 3) == 0);
      redir_ex_valid  = ($urandom_range(0, 11) == 0);
      redir_ex_target = $urandom;
      redir_id_valid  = ($urandom_range(0, 11) == 0);
      redir_id_target = $urandom;
      imem_rdata      = $urandom;
      imem_rvalid     = (q.size() > 0 && q[0].rdy <= cyc && $urandom_range(0, 2) != 0);
      m_req           = (q.size() == 0) && !m_sv && !stall;
      imem_gnt        = m_req && ($urandom_range(0, 2) != 0);
      #1;
      redirect = redir_ex_valid || redir_id_valid;
      checks++;
      if (imem_req !== m_req || (m_req && imem_addr !== m_pc) ||
          flush_ifid !== redirect || flush_idex !== redir_ex_valid) begin
        failures++; bad++;
        if (bad < 10) $display("FAIL rnd_req cyc=%0d got=%0b/%h/%0b%0b exp=%0b/%h/%0b%0b", cyc, imem_req, imem_addr, flush_ifid, flush_idex, m_req, m_pc, redirect, redir_ex_valid);
      end
      tgt = (redir_ex_valid ? redir_ex_target : redir_id_target) & 32'hFFFF_FFFC;
      acc = m_req && imem_gnt;
      live_rsp = 0;
      if (imem_rvalid) begin
        e = q.pop_front();
        live_rsp = e.live;
      end
      if (redirect) begin
        foreach (q[i]) q[i].live = 0;
        if (acc) begin e.pc = m_pc; e.live = 0; e.rdy = cyc + 1; q.push_back(e); end
        m_pc = tgt; m_ov = 0; m_sv = 0;
      end else begin
        loaded = 0;
        if (live_rsp && !stall) begin m_ov = 1; m_opc = e.pc; m_oin = imem_rdata; loaded = 1; end
        else if (live_rsp) begin m_sv = 1; m_spc = e.pc; m_sin = imem_rdata; loaded = 1; end
        if (!stall && !loaded) begin
          if (m_sv) begin m_ov = 1; m_opc = m_spc; m_oin = m_sin; m_sv = 0; end
          else m_ov = 0;
        end
        if (acc) begin e.pc = m_pc; e.live = 1; e.rdy = cyc + 1; q.push_back(e); m_pc = m_pc + 32'd4; end
      end
      tick();
      cyc++;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_boot();
    test_stall_rsp();
    test_redirect_wait();
    test_simul_redir();
    test_gnt_redirect();
    test_wrap();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Consumer end of the PC-redirect path. Owns the architectural fetch PC and issues instruction-memory requests over a req/gnt/rvalid handshake.
- Applies redirect targets from ID (jal/jalr) and EX (taken branch). Delivers fetched instructions to the IF/ID register, discarding stale in-flight responses.
- Generates the pipeline flush strobes that accompany a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
redir_id_valid  in  1  jal/jalr resolved in ID this cycle
redir_id_target  in  32  ID redirect target
redir_ex_valid  in  1  taken branch resolved in EX this cycle
redir_ex_target  in  32  EX redirect target
stall  in  1  hazard unit: hold IF/ID outputs, issue nothing new
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (current fetch PC)
imem_gnt  in  1  memory accepts request this cycle (valid only with imem_req)
imem_rvalid  in  1  response valid, exactly one per granted request, ≥1 cycle after gnt
imem_rdata  in  32  response instruction
if_valid  out  1  instr_if/pc_if hold a live instruction
pc_if  out  32  PC of instr_if
instr_if  out  32  fetched instruction
flush_ifid  out  1  squash IF/ID register
flush_idex  out  1  squash ID/EX register

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- Reset values:
  - fetch_pc=RESET_PC; state=FETCH; buf_valid=0.
  - if_valid=0; pc_if=0; instr_if=0.
  - imem_req=0 and flush_*=0 while rst is high.
- Redirect selection:
  - redir_ex_valid has priority over redir_id_valid; EX is the older instruction.
  - Selected target has bits [1:0] forced to 0.
- Flush strobes are combinational, asserted in the redirect cycle:
  - flush_ifid = redir_ex_valid | redir_id_valid.
  - flush_idex = redir_ex_valid.
- States:
  - FETCH: no request outstanding.
  - WAIT: one request outstanding, response wanted.
  - DROP: one request outstanding, response to be discarded.
- Outstanding requests: at most one at any time.
- Request issue:
  - imem_req = (state==FETCH) & !buf_valid & !stall & !rst.
  - imem_addr = fetch_pc.
  - Addr held stable until gnt, except when a redirect changes fetch_pc.
- FETCH, gnt without redirect: pend_pc<=fetch_pc; fetch_pc<=fetch_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); ->WAIT.
- WAIT, rvalid without redirect:
  - If !stall: if_valid<=1, pc_if<=pend_pc, instr_if<=imem_rdata.
  - If stall: capture into 1-entry skid buffer (buf_valid<=1).
  - Either way ->FETCH.
- Output register advance, when !stall and no redirect:
  - buf_valid: outputs<=buffer, buf_valid<=0.
  - Else if no response this cycle: if_valid<=0.
- Stall with no redirect: if_valid/pc_if/instr_if hold.
- Redirect, any state; overrides stall:
  - fetch_pc<=target; if_valid<=0; buf_valid<=0.
  - FETCH with gnt this cycle (old address accepted) ->DROP.
  - FETCH without gnt ->FETCH.
  - WAIT with rvalid this cycle: response discarded, ->FETCH.
  - WAIT without rvalid ->DROP.
  - DROP with rvalid ->FETCH; DROP without rvalid ->DROP, target retained.
- DROP without redirect: rvalid discarded, ->FETCH; outputs unaffected.
- Timing: minimum gnt-to-if_valid latency is 2 edges (rvalid next cycle, registered into outputs). Sustained throughput is one instruction per 2 cycles.
- rst mid-transaction: state forced to FETCH. Any later rvalid is ignored because state!=WAIT/DROP; memory must also be reset.

Test Plan:
- Boot: release rst, gnt=1 immediately, rvalid one cycle after each gnt -> imem_addr 0x0,0x4,0x8; if_valid pulses with pc_if 0x0,0x4,0x8 and matching instr_if.
- Stall during response: stall=1 in cycle rvalid returns instr 0x00500093 @0x4 -> outputs hold previous; on stall release pc_if=0x4, instr_if=0x00500093; no imem_req while buffered.
- Redirect while WAIT: redir_ex_valid=1 target 0x100 before rvalid -> flush_ifid=flush_idex=1 that cycle; next response dropped; next imem_addr=0x100; if_valid stays 0 until 0x100 returns.
- Simultaneous redirects: redir_id 0x200 and redir_ex 0x300 same cycle -> fetch_pc=0x300, flush_idex=1; target 0x302 -> imem_addr 0x300.
- Wrap/misc: RESET_PC=0xFFFFFFFC -> second imem_addr=0x0. Redirect in same cycle as gnt -> DROP; that response discarded.
